n_stage_hazard_scoreboard: RTL and testbench

//  Parametrised decode-side hazard/bypass engine for in-order cores of any depth.

---
 rtl/n_stage_hazard_scoreboard_if.sv | 36 +++
 rtl/n_stage_hazard_scoreboard.sv | 97 +++++++++
 tb/tb_n_stage_hazard_scoreboard.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/n_stage_hazard_scoreboard_if.sv
// Decode-side bundle for the hazard scoreboard: decode drives issue/source/control
// fields (master), the scoreboard answers with stall, bypass selects and the stall counter (slave).
interface n_stage_hazard_scoreboard_if #(
  parameter int NUM_STAGES = 4,
  parameter int REG_BITS   = 5,
  parameter int COUNT_BITS = 32,
  parameter int SEL_BITS   = $clog2(NUM_STAGES + 1)
);
  logic                  issue_valid;
  logic [REG_BITS-1:0]   rs1;
  logic [REG_BITS-1:0]   rs2;
  logic                  rs1_read;
  logic                  rs2_read;
  logic [REG_BITS-1:0]   issue_rd;
  logic                  issue_regWrite;
  logic                  issue_load;
  logic                  hold;
  logic                  flush_decode;
  logic [NUM_STAGES-1:0] flush_mask;
  logic                  stall_decode;
  logic [SEL_BITS-1:0]   rs1_bypass;
  logic [SEL_BITS-1:0]   rs2_bypass;
  logic [COUNT_BITS-1:0] stall_cycles;

  modport master (
    output issue_valid, rs1, rs2, rs1_read, rs2_read, issue_rd, issue_regWrite,
           issue_load, hold, flush_decode, flush_mask,
    input  stall_decode, rs1_bypass, rs2_bypass, stall_cycles
  );

  modport slave (
    input  issue_valid, rs1, rs2, rs1_read, rs2_read, issue_rd, issue_regWrite,
           issue_load, hold, flush_decode, flush_mask,
    output stall_decode, rs1_bypass, rs2_bypass, stall_cycles
  );
endinterface

// File: rtl/n_stage_hazard_scoreboard.sv
// Hazard/bypass scoreboard: tracks in-flight writers in a NUM_STAGES shift register
// (stage 0 = execute) and derives load-use stall plus youngest-producer bypass selects.
module n_stage_hazard_scoreboard #(
  parameter int NUM_STAGES       = 4,
  parameter int REG_BITS         = 5,
  parameter int LOAD_READY_STAGE = 3,
  parameter int COUNT_BITS       = 32,
  localparam int SEL_BITS        = $clog2(NUM_STAGES + 1)
) (
  input logic                    clock,
  input logic                    reset,
  n_stage_hazard_scoreboard_if.slave bus
);

  typedef struct packed {
    logic                valid;
    logic [REG_BITS-1:0] rd;
    logic                wr;
    logic                ld;
  } entry_t;

  entry_t [NUM_STAGES-1:0] pipe_q, pipe_d;
  logic [COUNT_BITS-1:0]   stall_cycles_q, stall_cycles_d;

  logic [SEL_BITS:0]       rs1_res, rs2_res;
  logic                    stall_w;
  logic                    insert_w;

  // Returns {hazard, select}; the lowest matching stage is the youngest producer.
  function automatic logic [SEL_BITS:0] search(input logic [REG_BITS-1:0] rs,
                                               input logic rd_en,
                                               input entry_t [NUM_STAGES-1:0] p);
    logic              found;
    logic [SEL_BITS:0] r;
    found = 1'b0;
    r     = '0;
    if (rd_en && rs != '0) begin
      for (int k = 0; k < NUM_STAGES; k++) begin
        if (!found && p[k].valid && p[k].wr && p[k].rd == rs) begin
          found = 1'b1;
          if (p[k].ld && k < LOAD_READY_STAGE) r = {1'b1, {SEL_BITS{1'b0}}};
          else                                 r = {1'b0, SEL_BITS'(k + 1)};
        end
      end
    end
    return r;
  endfunction

  always_comb begin
    rs1_res  = search(bus.rs1, bus.rs1_read, pipe_q);
    rs2_res  = search(bus.rs2, bus.rs2_read, pipe_q);
    stall_w  = bus.issue_valid && !bus.flush_decode && (rs1_res[SEL_BITS] || rs2_res[SEL_BITS]);
    insert_w = bus.issue_valid && !bus.flush_decode && !stall_w;
  end

  assign bus.stall_decode = stall_w;
  assign bus.rs1_bypass   = rs1_res[SEL_BITS-1:0];
  assign bus.rs2_bypass   = rs2_res[SEL_BITS-1:0];
  assign bus.stall_cycles = stall_cycles_q;

  // A frozen pipeline still honours flushes, but neither shifts nor inserts.
  always_comb begin
    pipe_d = pipe_q;
    if (bus.hold) begin
      for (int i = 0; i < NUM_STAGES; i++) begin
        if (bus.flush_mask[i]) pipe_d[i].valid = 1'b0;
      end
    end else begin
      for (int i = 1; i < NUM_STAGES; i++) begin
        pipe_d[i] = pipe_q[i-1];
        if (bus.flush_mask[i-1]) pipe_d[i].valid = 1'b0;
      end
      pipe_d[0] = '0;
      if (insert_w) begin
        pipe_d[0] = '{valid: 1'b1, rd: bus.issue_rd, wr: bus.issue_regWrite, ld: bus.issue_load};
      end
    end
  end

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (stall_w && !bus.hold && stall_cycles_q != {COUNT_BITS{1'b1}}) begin
      stall_cycles_d = stall_cycles_q + COUNT_BITS'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pipe_q         <= '0;
      stall_cycles_q <= '0;
    end else begin
      pipe_q         <= pipe_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

endmodule

// File: tb/tb_n_stage_hazard_scoreboard.sv
// Self-checking bench: directed scenarios with literal expectations, then random traffic
// compared every cycle against a stage-list reference model (default and 2-bit-counter instances).
module tb_n_stage_hazard_scoreboard;
  localparam int NS  = 4;
  localparam int RB  = 5;
  localparam int LRS = 3;
  localparam int SB  = $clog2(NS + 1);

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          issue_valid, rs1_read, rs2_read, issue_regWrite, issue_load, hold, flush_decode;
  logic [RB-1:0] rs1, rs2, issue_rd;
  logic [NS-1:0] flush_mask;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  n_stage_hazard_scoreboard_if #(.NUM_STAGES(NS), .REG_BITS(RB), .COUNT_BITS(32)) bus_m ();
  n_stage_hazard_scoreboard_if #(.NUM_STAGES(NS), .REG_BITS(RB), .COUNT_BITS(2))  bus_s ();

  assign bus_m.issue_valid = issue_valid;       assign bus_s.issue_valid = issue_valid;
  assign bus_m.rs1 = rs1;                       assign bus_s.rs1 = rs1;
  assign bus_m.rs2 = rs2;                       assign bus_s.rs2 = rs2;
  assign bus_m.rs1_read = rs1_read;             assign bus_s.rs1_read = rs1_read;
  assign bus_m.rs2_read = rs2_read;             assign bus_s.rs2_read = rs2_read;
  assign bus_m.issue_rd = issue_rd;             assign bus_s.issue_rd = issue_rd;
  assign bus_m.issue_regWrite = issue_regWrite; assign bus_s.issue_regWrite = issue_regWrite;
  assign bus_m.issue_load = issue_load;         assign bus_s.issue_load = issue_load;
  assign bus_m.hold = hold;                     assign bus_s.hold = hold;
  assign bus_m.flush_decode = flush_decode;     assign bus_s.flush_decode = flush_decode;
  assign bus_m.flush_mask = flush_mask;         assign bus_s.flush_mask = flush_mask;

  n_stage_hazard_scoreboard #(.NUM_STAGES(NS), .REG_BITS(RB), .LOAD_READY_STAGE(LRS), .COUNT_BITS(32))
    dut_m (.clock(clock), .reset(reset), .bus(bus_m.slave));
  n_stage_hazard_scoreboard #(.NUM_STAGES(NS), .REG_BITS(RB), .LOAD_READY_STAGE(LRS), .COUNT_BITS(2))
    dut_s (.clock(clock), .reset(reset), .bus(bus_s.slave));

  // Reference model: list of in-flight instructions, index = stage, plus an unbounded stall count.
  typedef struct {
    bit valid;
    int rd;
    bit wr;
    bit ld;
  } ent_t;

  ent_t   m_pipe[NS];
  longint m_count  = 0;
  bit     model_ok = 1'b0;

  function automatic void predict(input int rs, input bit rd_en, output bit haz, output int sel);
    haz = 1'b0;
    sel = 0;
    if (!rd_en || rs == 0) return;
    for (int k = 0; k < NS; k++) begin
      if (m_pipe[k].valid && m_pipe[k].wr && m_pipe[k].rd == rs) begin
        if (m_pipe[k].ld && k < LRS) haz = 1'b1;
        else sel = k + 1;
        return;
      end
    end
  endfunction

  function automatic bit model_stall();
    bit h1, h2;
    int s1, s2;
    predict(int'(rs1), rs1_read, h1, s1);
    predict(int'(rs2), rs2_read, h2, s2);
    return issue_valid && !flush_decode && (h1 || h2);
  endfunction

  always @(posedge clock) begin
    if (reset) begin
      for (int k = 0; k < NS; k++) m_pipe[k] = '{0, 0, 0, 0};
      m_count  = 0;
      model_ok = 1'b1;
    end else if (model_ok) begin
      bit   st;
      ent_t nxt[NS];
      st = model_stall();
      if (st && !hold) m_count++;
      if (hold) begin
        for (int k = 0; k < NS; k++) if (flush_mask[k]) m_pipe[k].valid = 1'b0;
      end else begin
        for (int k = NS - 1; k >= 1; k--) begin
          nxt[k] = m_pipe[k-1];
          if (flush_mask[k-1]) nxt[k].valid = 1'b0;
        end
        if (issue_valid && !flush_decode && !st) nxt[0] = '{1, int'(issue_rd), issue_regWrite, issue_load};
        else nxt[0] = '{0, 0, 0, 0};
        m_pipe = nxt;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge clock) begin
    if (model_ok) begin
      bit     h1, h2;
      int     s1, s2;
      longint lim_m, lim_s;
      predict(int'(rs1), rs1_read, h1, s1);
      predict(int'(rs2), rs2_read, h2, s2);
      lim_m = (m_count > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : m_count;
      lim_s = (m_count > 3) ? 3 : m_count;
      checkOutput("cmp_stall",      64'(bus_m.stall_decode), 64'(issue_valid && !flush_decode && (h1 || h2)));
      checkOutput("cmp_rs1_bypass", 64'(bus_m.rs1_bypass),   64'(s1));
      checkOutput("cmp_rs2_bypass", 64'(bus_m.rs2_bypass),   64'(s2));
      checkOutput("cmp_count",      64'(bus_m.stall_cycles), 64'(lim_m));
      checkOutput("cmp_stall_s",    64'(bus_s.stall_decode), 64'(issue_valid && !flush_decode && (h1 || h2)));
      checkOutput("cmp_count_sat",  64'(bus_s.stall_cycles), 64'(lim_s));
    end
  end

  task automatic applyStimulus(input bit v, input int a1, input bit e1, input int a2, input bit e2,
                               input int rd, input bit wr, input bit ld, input bit h, input bit fd,
                               input logic [NS-1:0] mask);
    issue_valid = v;    rs1 = RB'(a1);     rs1_read = e1;   rs2 = RB'(a2);       rs2_read = e2;
    issue_rd = RB'(rd); issue_regWrite = wr; issue_load = ld; hold = h; flush_decode = fd;
    flush_mask = mask;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_drain();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, '0);
    repeat (NS) tick();
  endtask

  initial begin
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, '0);
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    @(negedge clock);
    checkOutput("reset_stall",  64'(bus_m.stall_decode), 64'd0);
    checkOutput("reset_rs1",    64'(bus_m.rs1_bypass),   64'd0);
    checkOutput("reset_rs2",    64'(bus_m.rs2_bypass),   64'd0);
    checkOutput("reset_count",  64'(bus_m.stall_cycles), 64'd0);
    tick();

    // ADD x5 then consumer of x5 one cycle later
    applyStimulus(1, 0, 0, 0, 0, 5, 1, 0, 0, 0, '0); tick();
    applyStimulus(1, 5, 1, 0, 0, 0, 0, 0, 0, 0, '0);
    @(negedge clock);
    checkOutput("add_rs1_bypass", 64'(bus_m.rs1_bypass),   64'd1);
    checkOutput("add_no_stall",   64'(bus_m.stall_decode), 64'd0);
    tick(); idle_drain();

    // LW x6 then consumer on rs2: three stall cycles, then bypass from stage 3
    applyStimulus(1, 0, 0, 0, 0, 6, 1, 1, 0, 0, '0); tick();
    applyStimulus(1, 0, 0, 6, 1, 0, 0, 0, 0, 0, '0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      checkOutput("lw_stall",      64'(bus_m.stall_decode), 64'd1);
      checkOutput("lw_rs2_bypass", 64'(bus_m.rs2_bypass),   64'd0);
      tick();
    end
    @(negedge clock);
    checkOutput("lw_ready_bypass", 64'(bus_m.rs2_bypass),   64'd4);
    checkOutput("lw_ready_stall",  64'(bus_m.stall_decode), 64'd0);
    checkOutput("lw_count",        64'(bus_m.stall_cycles), 64'd3);
    tick(); idle_drain();

    // Youngest producer shadows an older load to the same register
    applyStimulus(1, 0, 0, 0, 0, 7, 1, 1, 0, 0, '0); tick();
    applyStimulus(1, 0, 0, 0, 0, 9, 1, 0, 0, 0, '0); tick();
    applyStimulus(1, 0, 0, 0, 0, 7, 1, 0, 0, 0, '0); tick();
    applyStimulus(1, 7, 1, 0, 0, 0, 0, 0, 0, 0, '0);
    @(negedge clock);
    checkOutput("young_rs1_bypass", 64'(bus_m.rs1_bypass),   64'd1);
    checkOutput("young_no_stall",   64'(bus_m.stall_decode), 64'd0);
    tick(); idle_drain();

    // Flushing the load in stage 1 removes the hazard
    applyStimulus(1, 0, 0, 0, 0, 8, 1, 1, 0, 0, '0); tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, '0); tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0010); tick();
    applyStimulus(1, 8, 1, 0, 0, 0, 0, 0, 0, 0, '0);
    @(negedge clock);
    checkOutput("flush_no_stall",   64'(bus_m.stall_decode), 64'd0);
    checkOutput("flush_rs1_bypass", 64'(bus_m.rs1_bypass),   64'd0);
    tick(); idle_drain();

    // Hold freezes a pending load-use stall without counting
    applyStimulus(1, 0, 0, 0, 0, 6, 1, 1, 0, 0, '0); tick();
    applyStimulus(1, 0, 0, 6, 1, 0, 0, 0, 1, 0, '0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      checkOutput("hold_stall", 64'(bus_m.stall_decode), 64'd1);
      checkOutput("hold_count", 64'(bus_m.stall_cycles), 64'd3);
      tick();
    end
    hold = 1'b0;
    repeat (3) tick();
    @(negedge clock);
    checkOutput("hold_release_bypass", 64'(bus_m.rs2_bypass),   64'd4);
    checkOutput("hold_release_count",  64'(bus_m.stall_cycles), 64'd6);
    checkOutput("sat_count",           64'(bus_s.stall_cycles), 64'd3);
    tick(); idle_drain();

    // Random traffic, small register range to provoke frequent matches
    for (int n = 0; n < 3000; n++) begin
      logic [NS-1:0] m;
      for (int b = 0; b < NS; b++) m[b] = ($urandom_range(0, 9) == 0);
      applyStimulus($urandom_range(0, 3) != 0, int'($urandom_range(0, 7)), $urandom_range(0, 3) != 0,
                    int'($urandom_range(0, 7)), $urandom_range(0, 1) == 1, int'($urandom_range(0, 7)),
                    $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 3, $urandom_range(0, 4) == 0,
                    $urandom_range(0, 9) == 0, m);
      reset = ($urandom_range(0, 199) == 0);
      tick();
    end

    // Reset while held and flushing clears everything
    applyStimulus(1, 3, 1, 4, 1, 3, 1, 1, 1, 0, '1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, '0);
    @(negedge clock);
    checkOutput("final_reset_stall", 64'(bus_m.stall_decode), 64'd0);
    checkOutput("final_reset_rs1",   64'(bus_m.rs1_bypass),   64'd0);
    checkOutput("final_reset_rs2",   64'(bus_m.rs2_bypass),   64'd0);
    checkOutput("final_reset_count", 64'(bus_m.stall_cycles), 64'd0);
    checkOutput("final_reset_sat",   64'(bus_s.stall_cycles), 64'd0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
